regulator_trim_cal: RTL and testbench

//   Multi-channel successive-approximation (SAR) trim calibrator for on-chip regulators.
//   For each enabled channel it searches the signed trim code using a per-channel

---
 rtl/regulator_trim_cal.sv | 166 ++++++++++++++++
 tb/tb_regulator_trim_cal.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/regulator_trim_cal.sv
// Multi-channel SAR trim calibrator: binary-searches the signed trim code of each
// enabled regulator against its comparator flag, then holds the converged code.
module regulator_trim_cal #(
  parameter int N_CH       = 2,
  parameter int TRIM_W     = 4,
  parameter int SETTLE_CYC = 8,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [N_CH-1:0]        ch_en,
  input  logic [N_CH-1:0]        cmp_hi,
  output logic [N_CH*TRIM_W-1:0] trim,
  output logic [CH_W-1:0]        ch_idx,
  output logic                   busy,
  output logic                   done
);

  localparam int BIT_W  = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
  localparam int SCAN_W = CH_W + 1;
  // Offset-binary <-> two's complement is a flip of the sign bit.
  localparam logic [TRIM_W-1:0] MSB_FLIP = TRIM_W'(1) << (TRIM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEL    = 3'd1,
    S_SET    = 3'd2,
    S_SETTLE = 3'd3,
    S_SAMPLE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                  r_state;
  logic [N_CH*TRIM_W-1:0]  r_trim;
  logic [N_CH*TRIM_W-1:0]  r_backup;
  logic [N_CH-1:0]         r_mask;
  logic [SCAN_W-1:0]       r_scan;
  logic [CH_W-1:0]         r_ch_idx;
  logic [TRIM_W-1:0]       r_u;
  logic [BIT_W-1:0]        r_bit;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_found;
  logic [CH_W-1:0]         w_next;
  logic                    w_cmp;
  logic [TRIM_W-1:0]       w_bit_mask;
  logic [TRIM_W-1:0]       w_u_set;
  logic [TRIM_W-1:0]       w_u_smp;
  logic                    w_abort_act;

  // Lowest enabled channel at or above the scan pointer (descending loop, lowest wins).
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      w_found = (r_mask[c] && (SCAN_W'(c) >= r_scan)) ? 1'b1 : w_found;
      w_next  = (r_mask[c] && (SCAN_W'(c) >= r_scan)) ? CH_W'(c) : w_next;
    end
  end

  // Candidate codes for the bit under trial.
  always_comb begin
    w_cmp       = cmp_hi[r_ch_idx];
    w_bit_mask  = TRIM_W'(1) << r_bit;
    w_u_set     = r_u | w_bit_mask;
    w_u_smp     = w_cmp ? (r_u & ~w_bit_mask) : r_u;
    w_abort_act = abort && (r_state != S_IDLE) && (r_state != S_DONE);
  end

  // Calibration sequencer with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_trim   <= '0;
      r_backup <= '0;
      r_mask   <= '0;
      r_scan   <= '0;
      r_ch_idx <= '0;
      r_u      <= '0;
      r_bit    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (w_abort_act) begin
      // In SEL no channel has been touched yet, so there is nothing to restore.
      if (r_state != S_SEL) begin
        r_trim[r_ch_idx*TRIM_W +: TRIM_W] <= r_backup[r_ch_idx*TRIM_W +: TRIM_W];
      end
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ch_idx <= '0;
      r_scan   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_mask   <= ch_en;
            r_backup <= r_trim;
            r_scan   <= '0;
            r_ch_idx <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_SEL;
          end
        end
        S_SEL: begin
          if (w_found) begin
            r_ch_idx <= w_next;
            r_u      <= '0;
            r_bit    <= BIT_W'(TRIM_W - 1);
            r_state  <= S_SET;
          end else begin
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_SET: begin
          r_u                               <= w_u_set;
          r_trim[r_ch_idx*TRIM_W +: TRIM_W] <= w_u_set ^ MSB_FLIP;
          r_cnt                             <= CNT_W'(SETTLE_CYC);
          r_state                           <= S_SETTLE;
        end
        S_SETTLE: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          r_u                               <= w_u_smp;
          r_trim[r_ch_idx*TRIM_W +: TRIM_W] <= w_u_smp ^ MSB_FLIP;
          if (r_bit != '0) begin
            r_bit   <= r_bit - BIT_W'(1);
            r_state <= S_SET;
          end else begin
            r_scan  <= SCAN_W'(r_ch_idx) + SCAN_W'(1);
            r_state <= S_SEL;
          end
        end
        S_DONE: begin
          r_busy   <= 1'b0;
          r_ch_idx <= '0;
          r_scan   <= '0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign trim   = r_trim;
  assign ch_idx = r_ch_idx;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_regulator_trim_cal.sv
// Directed and randomized bench for regulator_trim_cal, checked against a
// behavioural model that exhaustively scans codes for the largest one with cmp_hi=0.
module tb_regulator_trim_cal;

  localparam int NC = 2;
  localparam int TW = 4;
  localparam int SC = 8;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic            abort;
  logic [NC-1:0]   ch_en;
  logic [NC-1:0]   cmp_hi;
  logic [NC*TW-1:0] trim;
  logic [0:0]      ch_idx;
  logic            busy;
  logic            done;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int tgt [NC];
  int mdl [NC];
  bit force_hi = 1'b0;

  always #5 clk = ~clk;

  regulator_trim_cal #(.N_CH(NC), .TRIM_W(TW), .SETTLE_CYC(SC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .ch_en(ch_en),
    .cmp_hi(cmp_hi), .trim(trim), .ch_idx(ch_idx), .busy(busy), .done(done)
  );

  // Regulator stand-in: vout is above target whenever the trim exceeds the target code.
  assign cmp_hi[0] = force_hi | (int'($signed(trim[TW-1:0])) > tgt[0]);
  assign cmp_hi[1] = force_hi | (int'($signed(trim[2*TW-1:TW])) > tgt[1]);

  always @(negedge clk) if (done) n_done++;

  function automatic int trim_of(input int c);
    logic signed [TW-1:0] v;
    v = trim[c*TW +: TW];
    return int'(v);
  endfunction

  // Largest code whose comparator reads 0; minimum code if none does.
  function automatic int ref_code(input int t, input bit hi);
    int best;
    best = -(1 << (TW - 1));
    for (int v = -(1 << (TW - 1)); v < (1 << (TW - 1)); v++)
      if (!(hi || (v > t))) best = v;
    return best;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_trims(input string tag);
    chk({tag, "_trim0"}, trim_of(0), mdl[0]);
    chk({tag, "_trim1"}, trim_of(1), mdl[1]);
  endtask

  task automatic run_cal(input logic [NC-1:0] en, input int restart_at, input string tag);
    int k;
    int j;
    int exp_lat;
    bit seen;
    bit busy_ok;
    k = int'(en[0]) + int'(en[1]);
    exp_lat = 1 + k * (1 + TW * (SC + 2)) + 1;
    for (int c = 0; c < NC; c++) if (en[c]) mdl[c] = ref_code(tgt[c], force_hi);
    @(negedge clk);
    ch_en = en;
    start = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    busy_ok = 1'b1;
    j = 0;
    while (!seen && j < 4000) begin
      @(negedge clk);
      start = (j == restart_at);
      if (done) seen = 1'b1;
      else begin
        if (!busy) busy_ok = 1'b0;
        j++;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_latency"}, j + 1, exp_lat);
    chk({tag, "_busy_held"}, int'(busy_ok), 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_ch_idx_end"}, int'(ch_idx), 0);
    chk_trims(tag);
  endtask

  initial begin
    int nd0;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ch_en = '0;
    tgt[0] = 0;
    tgt[1] = 0;
    mdl[0] = 0;
    mdl[1] = 0;
    repeat (3) @(negedge clk);
    chk("rst_trim", int'(trim), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ch_idx", int'(ch_idx), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of a calibration discards partial results.
    tgt[0] = 5;
    tgt[1] = -3;
    ch_en = 2'b11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    nd0 = n_done;
    reset_n = 1'b0;
    #1;
    chk("midrst_trim", int'(trim), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("midrst_no_done", n_done, nd0);
    run_cal(2'b11, -1, "recal");

    tgt[0] = 3;
    tgt[1] = -2;
    run_cal(2'b11, -1, "t3m2");

    tgt[0] = 7;
    tgt[1] = -8;
    run_cal(2'b11, -1, "extreme");
    force_hi = 1'b1;
    run_cal(2'b11, -1, "allhi");
    force_hi = 1'b0;

    tgt[0] = 5;
    run_cal(2'b01, -1, "pre_ch0");
    tgt[0] = -6;
    tgt[1] = -1;
    run_cal(2'b10, -1, "only_ch1");
    run_cal(2'b00, -1, "none");

    // Abort during the first bit of ch1 after ch0 has converged.
    tgt[1] = 2;
    run_cal(2'b10, -1, "pre_abort");
    tgt[0] = 4;
    tgt[1] = -5;
    mdl[0] = ref_code(tgt[0], 1'b0);
    @(negedge clk);
    ch_en = 2'b11;
    start = 1'b1;
    @(posedge clk);
    nd0 = n_done;
    for (int j = 0; j < 46; j++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_ch_idx", int'(ch_idx), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk_trims("abort");
    repeat (100) @(negedge clk);
    chk("abort_no_done", n_done, nd0);
    chk_trims("abort_hold");

    // Abort beats start while idle.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_start", int'(busy), 0);

    // A second start while busy must change neither result nor latency.
    tgt[0] = 3;
    tgt[1] = -2;
    run_cal(2'b11, 5, "restart");

    for (int i = 0; i < 4; i++) begin
      tgt[0] = int'($urandom_range(15)) - 8;
      tgt[1] = int'($urandom_range(15)) - 8;
      run_cal(NC'($urandom_range(3)), -1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
